pt_tx_engine: RTL and testbench

PT_TX_ENGINE -- requirements
Module: pt_tx_engine

---
 rtl/pt_pkg.sv | 27 ++
 rtl/pt_sym_gen.sv | 37 +++
 rtl/pt_tx_engine.sv | 143 ++++++++++++++
 tb/tb_pt_tx_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pt_pkg
// Purpose  : Code-bit types and tick-level waveform patterns for the PT2262-style TX engine.
// Revision : 1.0
// ============================================================================
package pt_pkg;

    typedef enum logic [1:0] {
        CB_ZERO  = 2'b00,
        CB_ONE   = 2'b01,
        CB_FLOAT = 2'b10,
        CB_RSVD  = 2'b11
    } cb_t;

    localparam int SYM_TICKS     = 32;
    localparam int SYNC_TICKS    = 128;
    localparam int SYNC_HI_TICKS = 4;

    // Bit 31 is tick 0; one bit per tick, 1 = line high.
    localparam logic [31:0] PAT_ZERO  = 32'hF000_F000;
    localparam logic [31:0] PAT_ONE   = 32'hFFF0_FFF0;
    localparam logic [31:0] PAT_FLOAT = 32'hF000_FFF0;
    localparam logic [31:0] PAT_RSVD  = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pt_sym_gen.sv
`default_nettype none
// ============================================================================
// Module   : pt_sym_gen
// Purpose  : Maps a code bit, tick index and sync flag to the line level.
// Revision : 1.0
// ============================================================================
module pt_sym_gen
    import pt_pkg::*;
(
    input  logic [1:0] i_cb,
    input  logic [6:0] i_tick,
    input  logic       i_sync,
    output logic       o_level
);

    logic [31:0] w_pat;

    always_comb begin
        w_pat = PAT_RSVD;
        case (cb_t'(i_cb))
            CB_ZERO:  w_pat = PAT_ZERO;
            CB_ONE:   w_pat = PAT_ONE;
            CB_FLOAT: w_pat = PAT_FLOAT;
            default:  w_pat = PAT_RSVD;
        endcase
    end

    always_comb begin
        if (i_sync) begin
            o_level = (i_tick < 7'(SYNC_HI_TICKS));
        end else begin
            o_level = w_pat[5'd31 - i_tick[4:0]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pt_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : pt_tx_engine
// Purpose  : PT2262-style tri-state serial transmitter; repeats each word REPEATS times.
//            Optional abort input enabled by defining PT_TX_ABORT_EN.
// Revision : 1.0
// ============================================================================
module pt_tx_engine
    import pt_pkg::*;
#(
    parameter int N_CB    = 12,
    parameter int DIV     = 4,
    parameter int REPEATS = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*N_CB-1:0] in_data,
    output logic              busy,
    output logic              q,
    output logic              frame_done
`ifdef PT_TX_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CODE = 2'd1;
    localparam logic [1:0] S_SYNC = 2'd2;

    localparam int c_DIV_W = (DIV > 1)  ? $clog2(DIV)  : 1;
    localparam int c_SYM_W = (N_CB > 1) ? $clog2(N_CB) : 1;
    localparam int c_FRM_W = $clog2(REPEATS + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(DIV - 1);
    localparam logic [c_SYM_W-1:0] c_SYM_LAST  = c_SYM_W'(N_CB - 1);
    localparam logic [c_FRM_W-1:0] c_FRM_LAST  = c_FRM_W'(REPEATS - 1);
    localparam logic [6:0]         c_CODE_LAST = 7'(SYM_TICKS - 1);
    localparam logic [6:0]         c_SYNC_LAST = 7'(SYNC_TICKS - 1);

    logic [1:0]         r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [6:0]         r_tick;
    logic [c_SYM_W-1:0] r_sym;
    logic [c_FRM_W-1:0] r_frm;
    logic [2*N_CB-1:0]  r_data;
    logic [2*N_CB-1:0]  r_shift;

    logic w_accept;
    logic w_abort;
    logic w_tick_end;
    logic w_sym_end;
    logic w_frame_end;
    logic w_level;

`ifdef PT_TX_ABORT_EN
    assign w_abort = abort & busy;
`else
    assign w_abort = 1'b0;
`endif

    assign in_ready    = (r_state == S_IDLE) & ~rst;
    assign busy        = (r_state != S_IDLE);
    assign w_accept    = in_valid & in_ready;
    assign w_tick_end  = (r_div == c_DIV_LAST);
    assign w_sym_end   = w_tick_end &
                         ((r_state == S_SYNC) ? (r_tick == c_SYNC_LAST) : (r_tick == c_CODE_LAST));
    assign w_frame_end = (r_state == S_SYNC) & w_sym_end;
    assign frame_done  = w_frame_end & ~w_abort & ~rst;
    assign q           = busy & w_level;

    // r_shift walks through the frame; r_data is kept intact to reload every repeat.
    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_tick  <= '0;
            r_sym   <= '0;
            r_frm   <= '0;
            if (rst) begin
                r_data  <= '0;
                r_shift <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_CODE;
                        r_data  <= in_data;
                        r_shift <= in_data;
                        r_div   <= '0;
                        r_tick  <= '0;
                        r_sym   <= '0;
                        r_frm   <= '0;
                    end
                end
                S_CODE: begin
                    r_div <= w_tick_end ? '0 : r_div + 1'b1;
                    if (w_tick_end) begin
                        r_tick <= w_sym_end ? 7'd0 : r_tick + 7'd1;
                    end
                    if (w_sym_end) begin
                        r_shift <= r_shift << 2;
                        if (r_sym == c_SYM_LAST) begin
                            r_sym   <= '0;
                            r_state <= S_SYNC;
                        end else begin
                            r_sym <= r_sym + 1'b1;
                        end
                    end
                end
                S_SYNC: begin
                    r_div <= w_tick_end ? '0 : r_div + 1'b1;
                    if (w_tick_end) begin
                        r_tick <= w_sym_end ? 7'd0 : r_tick + 7'd1;
                    end
                    if (w_frame_end) begin
                        if (r_frm != c_FRM_LAST) begin
                            r_frm   <= r_frm + 1'b1;
                            r_shift <= r_data;
                            r_state <= S_CODE;
                        end else begin
                            r_frm   <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    pt_sym_gen u_sym_gen (
        .i_cb    (r_shift[2*N_CB-1 -: 2]),
        .i_tick  (r_tick),
        .i_sync  (r_state == S_SYNC),
        .o_level (w_level)
    );

endmodule
`default_nettype wire

// File: tb/tb_pt_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pt_tx_engine
// Purpose  : Directed, table-driven self-checking bench for pt_tx_engine.
// Revision : 1.0
// ============================================================================
module tb_pt_tx_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // A: N_CB=2 DIV=1 REPEATS=1
    logic       a_valid, a_ready, a_busy, a_q, a_fd;
    logic [3:0] a_data;
    // B: N_CB=1 DIV=3 REPEATS=1
    logic       b_valid, b_ready, b_busy, b_q, b_fd;
    logic [1:0] b_data;
    // C: N_CB=2 DIV=2 REPEATS=3
    logic       c_valid, c_ready, c_busy, c_q, c_fd;
    logic [3:0] c_data;
`ifdef PT_TX_ABORT_EN
    logic a_abort, b_abort, c_abort;
`endif

    pt_tx_engine #(.N_CB(2), .DIV(1), .REPEATS(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .busy(a_busy), .q(a_q), .frame_done(a_fd)
`ifdef PT_TX_ABORT_EN
        , .abort(a_abort)
`endif
    );

    pt_tx_engine #(.N_CB(1), .DIV(3), .REPEATS(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .busy(b_busy), .q(b_q), .frame_done(b_fd)
`ifdef PT_TX_ABORT_EN
        , .abort(b_abort)
`endif
    );

    pt_tx_engine #(.N_CB(2), .DIV(2), .REPEATS(3)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
        .busy(c_busy), .q(c_q), .frame_done(c_fd)
`ifdef PT_TX_ABORT_EN
        , .abort(c_abort)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference waveform: k is the 1-based clk index within a frame.
    function automatic logic model_q(input logic [63:0] d, input int n_cb, input int div, input int k);
        int t, sym, tt;
        logic [1:0] cb;
        t   = (k - 1) / div;
        sym = t / 32;
        if (sym < n_cb) begin
            tt = t % 32;
            cb = d[2*(n_cb-1-sym) +: 2];
            case (cb)
                2'b00:   return (tt < 4) || (tt >= 16 && tt < 20);
                2'b01:   return (tt < 12) || (tt >= 16 && tt < 28);
                2'b10:   return (tt < 4) || (tt >= 16 && tt < 28);
                default: return 1'b0;
            endcase
        end
        return (t - 32*n_cb) < 4;
    endfunction

    typedef struct {
        logic [3:0] data;
        int         exp_high;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int werr, highs, fd_at, fd_cnt, rdy_err, len, rdy_low;
        logic prev;
        int runs[$];
        int fdpos[$];
        int exp_runs[6];

        vecs[0] = '{4'b0001, 36};
        vecs[1] = '{4'b0000, 20};
        vecs[2] = '{4'b1010, 36};
        vecs[3] = '{4'b1111, 4};
        vecs[4] = '{4'b0110, 44};
        vecs[5] = '{4'b1001, 44};
        exp_runs = '{12, 36, 36, 12, 12, 372};

        rst = 1'b1;
        a_valid = 0; b_valid = 0; c_valid = 0;
        a_data = '0; b_data = '0; c_data = '0;
`ifdef PT_TX_ABORT_EN
        a_abort = 0; b_abort = 0; c_abort = 0;
`endif
        repeat (3) @(negedge clk);
        check("rst_q", a_q, 0);
        check("rst_busy", a_busy, 0);
        check("rst_frame_done", a_fd, 0);
        check("rst_in_ready", a_ready, 0);
        check("rst_in_ready_c", c_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", a_ready, 1);
        check("post_rst_q", b_q, 0);

        // Table: one frame per vector on A, with data churn and stray valid mid-frame.
        for (int i = 0; i < 6; i++) begin
            check("a_ready_before", a_ready, 1);
            a_data  = vecs[i].data;
            a_valid = 1'b1;
            @(negedge clk);
            a_valid = 1'b0;
            werr = 0; highs = 0; fd_at = -1; fd_cnt = 0; rdy_err = 0;
            for (int k = 1; k <= 192; k++) begin
                if (a_q !== model_q({60'b0, vecs[i].data}, 2, 1, k)) werr++;
                if (a_q) highs++;
                if (a_fd) begin
                    fd_cnt++;
                    fd_at = k;
                end
                if (a_ready || !a_busy) rdy_err++;
                if (k == 10) a_data = ~vecs[i].data;
                if (k == 20) a_valid = 1'b1;
                if (k == 30) a_valid = 1'b0;
                @(negedge clk);
            end
            check("a_wave_errors", werr, 0);
            check("a_high_cycles", highs, vecs[i].exp_high);
            check("a_frame_done_at", fd_at, 192);
            check("a_frame_done_count", fd_cnt, 1);
            check("a_ready_busy_in_frame", rdy_err, 0);
            check("a_ready_after", a_ready, 1);
            check("a_busy_after", a_busy, 0);
            check("a_q_idle", a_q, 0);
        end

        // B: float symbol at DIV=3, checked as run lengths.
        b_data  = 2'b10;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        check("b_first_level", b_q, 1);
        prev = b_q; len = 0; fd_at = -1;
        for (int k = 1; k <= 480; k++) begin
            if (b_q === prev) begin
                len++;
            end else begin
                runs.push_back(len);
                prev = b_q;
                len  = 1;
            end
            if (b_fd) fd_at = k;
            @(negedge clk);
        end
        runs.push_back(len);
        check("b_run_count", runs.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b_run%0d", i), (i < runs.size()) ? runs[i] : -1, exp_runs[i]);
        end
        check("b_frame_done_at", fd_at, 480);
        check("b_ready_after", b_ready, 1);

        // C: three repeats with in_valid held; data changes right after accept.
        c_data  = 4'b1100;
        c_valid = 1'b1;
        @(negedge clk);
        c_data = 4'b0110;
        werr = 0; rdy_low = 0;
        for (int k = 1; k <= 1152; k++) begin
            if (c_q !== model_q({60'b0, 4'b1100}, 2, 2, ((k - 1) % 384) + 1)) werr++;
            if (!c_ready) rdy_low++;
            if (c_fd) fdpos.push_back(k);
            @(negedge clk);
        end
        check("c_wave_errors", werr, 0);
        check("c_ready_low_cycles", rdy_low, 1152);
        check("c_frame_done_count", fdpos.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("c_frame_done_at%0d", i), (i < fdpos.size()) ? fdpos[i] : -1, 384 * (i + 1));
        end
        check("c_ready_return", c_ready, 1);
        @(negedge clk);
        c_valid = 1'b0;
        check("c_second_accept_busy", c_busy, 1);

        // Second word runs to frame clk 50, then rst discards it.
        werr = 0; fd_cnt = 0;
        for (int k = 1; k <= 50; k++) begin
            if (c_q !== model_q({60'b0, 4'b0110}, 2, 2, k)) werr++;
            if (c_fd) fd_cnt++;
            if (k == 50) rst = 1'b1;
            @(negedge clk);
        end
        check("c_second_wave_errors", werr, 0);
        check("c_rst_q", c_q, 0);
        check("c_rst_busy", c_busy, 0);
        check("c_rst_ready_held", c_ready, 0);
        check("c_rst_frame_done", fd_cnt + int'(c_fd), 0);
        rst = 1'b0;
        @(negedge clk);
        check("c_ready_after_rst", c_ready, 1);

`ifdef PT_TX_ABORT_EN
        a_data  = 4'b0101;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        werr = 0; fd_cnt = 0;
        for (int k = 1; k <= 70; k++) begin
            if (a_q !== model_q({60'b0, 4'b0101}, 2, 1, k)) werr++;
            if (a_fd) fd_cnt++;
            if (k == 70) a_abort = 1'b1;
            @(negedge clk);
        end
        check("abort_pre_wave", werr, 0);
        check("abort_q", a_q, 0);
        check("abort_busy", a_busy, 0);
        check("abort_frame_done", fd_cnt + int'(a_fd), 0);
        a_data  = 4'b1000;
        a_valid = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        a_valid = 1'b0;
        check("abort_idle_accept_busy", a_busy, 1);
        werr = 0; fd_at = -1;
        for (int k = 1; k <= 192; k++) begin
            if (a_q !== model_q({60'b0, 4'b1000}, 2, 1, k)) werr++;
            if (a_fd) fd_at = k;
            @(negedge clk);
        end
        check("abort_fresh_wave", werr, 0);
        check("abort_fresh_frame_done", fd_at, 192);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
